// File: rtl/fix_serializer.sv
// fix_serializer: turns binary-tag/streamed-value fields into a FIX byte stream
// with an SOH preamble per message and a trailing "10=NNN" checksum field.
module fix_serializer #(
  parameter int          TAG_W = 14,
  parameter logic [7:0]  SOH_C = 8'h7c,
  parameter logic [7:0]  SEP_C = 8'h3d
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fld_valid_i,
  output logic             fld_ready_o,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             msg_last_i,
  input  logic             val_valid_i,
  input  logic [7:0]       val_data_i,
  input  logic             val_last_i,
  output logic             val_ready_o,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             tag_s_o,
  output logic             value_s_o,
  output logic             eom_o
);
  localparam int CW = $clog2(TAG_W + 1);
  typedef enum logic [3:0] {IDLE, PRE, CONV, TAG, SEP, VAL, FSOH, CKT, CKV, CKS} state_e;
  state_e           state_q, state_d;
  logic [TAG_W-1:0] bin_q, bin_d, bin_n;
  logic [19:0]      bcd_q, bcd_d, bcd_n, adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       dig_q, dig_d;
  logic             last_q, last_d, in_msg_q, in_msg_d;
  logic [7:0]       csum_q, csum_d, data_q, data_d, ck_dig;
  logic             valid_q, tag_s_q, tag_s_d, value_s_q, value_s_d, eom_q, eom_d, emit, adv;
  function automatic logic [2:0] msd(input logic [19:0] b);
    msd = 3'd0;
    for (int k = 1; k < 5; k++)
      if (b[4*k +: 4] != 4'd0) msd = 3'(k);
  endfunction
  assign adv       = !valid_q || ready_i;
  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign tag_s_o   = tag_s_q;
  assign value_s_o = value_s_q;
  assign eom_o     = eom_q;
  // One double-dabble step: add 3 to digits >= 5, then shift the next tag bit in.
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < 5; k++)
      if (bcd_q[4*k +: 4] > 4'd4) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
  end
  assign bcd_n  = {adj[18:0], bin_q[TAG_W-1]};
  assign bin_n  = bin_q << 1;
  assign ck_dig = dig_q == 3'd0 ? csum_q / 8'd100 : dig_q == 3'd1 ? (csum_q / 8'd10) % 8'd10 : csum_q % 8'd10;
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    dig_d       = dig_q;
    last_d      = last_q;
    in_msg_d    = in_msg_q;
    csum_d      = csum_q;
    data_d      = 8'h00;
    emit        = 1'b0;
    tag_s_d     = 1'b0;
    value_s_d   = 1'b0;
    eom_d       = 1'b0;
    fld_ready_o = state_q == IDLE;
    val_ready_o = state_q == VAL && adv;
    case (state_q)
      IDLE: if (fld_valid_i) begin
        bin_d   = tag_i;
        bcd_d   = '0;
        cnt_d   = '0;
        last_d  = msg_last_i;
        state_d = in_msg_q ? CONV : PRE;
      end
      // The preamble cycle also performs the first conversion step.
      PRE: if (adv) begin
        emit     = 1'b1;
        data_d   = SOH_C;
        in_msg_d = 1'b1;
        csum_d   = 8'h00;
        bin_d    = bin_n;
        bcd_d    = bcd_n;
        cnt_d    = cnt_q + 1'b1;
        state_d  = CONV;
      end
      CONV: if (adv) begin
        bin_d = bin_n;
        bcd_d = bcd_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(TAG_W - 1)) begin
          state_d = TAG;
          dig_d   = msd(bcd_n);
        end
      end
      TAG: if (adv) begin
        emit    = 1'b1;
        data_d  = {4'h3, bcd_q[4*dig_q +: 4]};
        tag_s_d = 1'b1;
        dig_d   = dig_q - 1'b1;
        if (dig_q == 3'd0) state_d = SEP;
      end
      SEP: if (adv) begin
        emit    = 1'b1;
        data_d  = SEP_C;
        state_d = VAL;
      end
      VAL: if (adv && val_valid_i) begin
        emit      = 1'b1;
        data_d    = val_data_i;
        value_s_d = 1'b1;
        if (val_last_i) state_d = FSOH;
      end
      FSOH: if (adv) begin
        emit    = 1'b1;
        data_d  = SOH_C;
        dig_d   = 3'd0;
        state_d = last_q ? CKT : IDLE;
      end
      CKT: if (adv) begin
        emit    = 1'b1;
        data_d  = dig_q == 3'd0 ? 8'h31 : dig_q == 3'd1 ? 8'h30 : SEP_C;
        tag_s_d = dig_q != 3'd2;
        dig_d   = dig_q == 3'd2 ? 3'd0 : dig_q + 1'b1;
        if (dig_q == 3'd2) state_d = CKV;
      end
      CKV: if (adv) begin
        emit      = 1'b1;
        data_d    = 8'h30 + ck_dig;
        value_s_d = 1'b1;
        dig_d     = dig_q == 3'd2 ? 3'd0 : dig_q + 1'b1;
        if (dig_q == 3'd2) state_d = CKS;
      end
      CKS: if (adv) begin
        emit     = 1'b1;
        data_d   = SOH_C;
        eom_d    = 1'b1;
        in_msg_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (emit && state_q inside {TAG, SEP, VAL, FSOH}) csum_d = csum_q + data_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      dig_q     <= '0;
      last_q    <= 1'b0;
      in_msg_q  <= 1'b0;
      csum_q    <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      tag_s_q   <= 1'b0;
      value_s_q <= 1'b0;
      eom_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      last_q   <= last_d;
      in_msg_q <= in_msg_d;
      csum_q   <= csum_d;
      if (adv) begin
        data_q    <= data_d;
        valid_q   <= emit;
        tag_s_q   <= tag_s_d;
        value_s_q <= value_s_d;
        eom_q     <= eom_d;
      end
    end
  end
endmodule

// File: tb/tb_fix_serializer.sv
// tb_fix_serializer: scoreboard bench; a string-level FIX model predicts every
// emitted byte and flag, a monitor pops and compares as bytes leave the DUT.
module tb_fix_serializer;
  localparam int TAG_W = 14;
  logic             clk = 1'b0, rst_n = 1'b0;
  logic             fld_valid_i = 1'b0, msg_last_i = 1'b0, fld_ready_o;
  logic [TAG_W-1:0] tag_i = '0;
  logic             val_valid_i = 1'b0, val_last_i = 1'b0, val_ready_o;
  logic [7:0]       val_data_i = 8'h00, data_o;
  logic             valid_o, ready_i = 1'b1, tag_s_o, value_s_o, eom_o;

  fix_serializer #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .fld_valid_i(fld_valid_i), .fld_ready_o(fld_ready_o),
    .tag_i(tag_i), .msg_last_i(msg_last_i), .val_valid_i(val_valid_i),
    .val_data_i(val_data_i), .val_last_i(val_last_i), .val_ready_o(val_ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .tag_s_o(tag_s_o),
    .value_s_o(value_s_o), .eom_o(eom_o)
  );

  always #5 clk = ~clk;

  // kind: 0 plain, 1 preamble, 2 first tag digit, 3 non-final field SOH, 4 closing SOH
  typedef struct {logic [7:0] d; logic ts; logic vs; logic eom; int kind;} item_t;
  item_t      exp_q[$];
  int         vectors = 0, miscompares = 0, cyc = 0, pre_cyc = 0;
  bit         chk_en = 1'b1, rnd_ready = 1'b0;
  int         ftag[$], flen[$];
  logic [7:0] fdat[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic ts, input logic vs, input logic eom, input int kind);
    exp_q.push_back('{d: d, ts: ts, vs: vs, eom: eom, kind: kind});
  endtask

  task automatic model_msg();
    logic [7:0] sum = 8'h00;
    string      s;
    int         p = 0;
    push(8'h7c, 0, 0, 0, 1);
    for (int f = 0; f < ftag.size(); f++) begin
      s = $sformatf("%0d", ftag[f]);
      for (int i = 0; i < s.len(); i++) begin
        push(s[i], 1, 0, 0, (f == 0 && i == 0) ? 2 : 0);
        sum += s[i];
      end
      push(8'h3d, 0, 0, 0, 0);
      sum += 8'h3d;
      for (int j = 0; j < flen[f]; j++) begin
        push(fdat[p+j], 0, 1, 0, 0);
        sum += fdat[p+j];
      end
      p += flen[f];
      push(8'h7c, 0, 0, 0, f == ftag.size() - 1 ? 0 : 3);
      sum += 8'h7c;
    end
    push("1", 1, 0, 0, 0);
    push("0", 1, 0, 0, 0);
    push("=", 0, 0, 0, 0);
    s = $sformatf("%03d", sum);
    for (int i = 0; i < 3; i++) push(s[i], 0, 1, 0, 0);
    push(8'h7c, 0, 0, 1, 4);
  endtask

  task automatic send_field(input int tag, input bit last);
    bit acc = 1'b0;
    fld_valid_i = 1'b1;
    tag_i       = tag[TAG_W-1:0];
    msg_last_i  = last;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk);
      acc = fld_ready_o;
      @(posedge clk);
      #1;
    end
    fld_valid_i = 1'b0;
    if (!acc) chk("field_accept_timeout", 0, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    bit acc = 1'b0;
    if (rnd_ready && $urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
    val_valid_i = 1'b1;
    val_data_i  = b;
    val_last_i  = last;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk);
      acc = val_ready_o;
      @(posedge clk);
      #1;
    end
    val_valid_i = 1'b0;
    if (!acc) chk("value_accept_timeout", 0, 1);
  endtask

  task automatic send_msg();
    int p = 0;
    model_msg();
    for (int f = 0; f < ftag.size(); f++) begin
      send_field(ftag[f], f == ftag.size() - 1);
      for (int j = 0; j < flen[f]; j++) send_byte(fdat[p+j], j == flen[f] - 1);
      p += flen[f];
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic set_msg1();
    ftag = {35}; flen = {1}; fdat = {8'h41};
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    item_t      e;
    logic [7:0] pd = 8'h00;
    logic       pv = 1'b0, pr = 1'b0, pts = 1'b0, pvs = 1'b0, peom = 1'b0, pok = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
        if (pok && pv && !pr)
          chk("hold", {data_o, valid_o, tag_s_o, value_s_o, eom_o}, {pd, pv, pts, pvs, peom});
        if (valid_o && !ready_i) chk("val_ready_backpressure", val_ready_o, 0);
        if (valid_o && ready_i) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_byte: got %0h expected none", data_o);
          end else begin
            e = exp_q.pop_front();
            chk("data", data_o, e.d);
            chk("flags_ts_vs_eom", {tag_s_o, value_s_o, eom_o}, {e.ts, e.vs, e.eom});
            if (!rnd_ready) begin
              chk("fld_ready", fld_ready_o, e.kind >= 3);
              if (e.kind == 1) pre_cyc = cyc;
              if (e.kind == 2) chk("tag_latency", cyc - pre_cyc, TAG_W);
            end
          end
        end
      end
      pok = rst_n && chk_en; pd = data_o; pv = valid_o; pr = ready_i;
      pts = tag_s_o; pvs = value_s_o; peom = eom_o;
    end
  end

  initial begin
    #2;
    chk("reset_outputs", {data_o, valid_o, tag_s_o, value_s_o, eom_o}, 0);
    chk("reset_fld_ready", fld_ready_o, 1);
    chk("reset_val_ready", val_ready_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    set_msg1();
    send_msg();
    drain();
    ftag = {8, 0}; flen = {3, 1}; fdat = {"F", "I", "X", "Z"};
    send_msg();
    drain();
    ftag = {16383}; flen = {1}; fdat = {8'($urandom)};
    send_msg();
    drain();
    rnd_ready = 1'b1;
    set_msg1();
    send_msg();
    drain();
    for (int m = 0; m < 15; m++) begin
      int nf;
      rnd_ready = 1'($urandom_range(0, 1));
      nf = $urandom_range(1, 3);
      ftag.delete(); flen.delete(); fdat.delete();
      for (int f = 0; f < nf; f++) begin
        ftag.push_back($urandom_range(0, 16383));
        flen.push_back($urandom_range(1, 4));
        for (int j = 0; j < flen[f]; j++) fdat.push_back(8'($urandom));
      end
      send_msg();
    end
    drain();
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    send_field(35, 1'b1);
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midmsg_reset_outputs", {data_o, valid_o, tag_s_o, value_s_o, eom_o}, 0);
    chk("midmsg_reset_val_ready", val_ready_o, 0);
    chk("midmsg_reset_fld_ready", fld_ready_o, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    chk_en = 1'b1;
    set_msg1();
    send_msg();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
